// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared sizes and FSM state encoding for the CPU bus arbiter.
package cpu_bus_arbiter_pkg;

  localparam int ADDR_SIZE = 16;
  localparam int DATA_SIZE = 16;
  // Wide enough for the largest timeout value (255).
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/cpu_bus_arbiter_rr_pick.sv
// Winner selection: the dispatcher core if it is requesting, otherwise the
// first requester found scanning upward from last_owner+1 (wrapping).
module cpu_bus_arbiter_rr_pick #(
  parameter int CPU_NUM = 4,
  parameter int IDX_W   = $clog2(CPU_NUM)
) (
  input  logic [CPU_NUM-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  input  logic [IDX_W-1:0]   prio_idx,
  output logic               valid,
  output logic [CPU_NUM-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [IDX_W:0] NUM_E = (IDX_W+1)'(CPU_NUM);

  logic [IDX_W:0] sum_s;
  logic [IDX_W:0] cand_s;
  logic           found_s;
  logic           hit_s;

  // Priority check first, then a wrapping scan that keeps the first hit.
  always_comb begin
    valid   = 1'b0;
    idx     = '0;
    sum_s   = '0;
    cand_s  = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    if (req[prio_idx]) begin
      valid = 1'b1;
      idx   = prio_idx;
    end else begin
      for (int i = 1; i <= CPU_NUM; i++) begin
        sum_s   = {1'b0, last_owner} + (IDX_W+1)'(i);
        cand_s  = (sum_s >= NUM_E) ? (sum_s - NUM_E) : sum_s;
        hit_s   = !found_s && req[cand_s[IDX_W-1:0]];
        idx     = hit_s ? cand_s[IDX_W-1:0] : idx;
        found_s = found_s | hit_s;
      end
      valid = found_s;
    end
    onehot = valid ? (CPU_NUM'(1) << idx) : '0;
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Multi-core bus arbiter: one tenure per grant, IDLE -> GRANT -> ACCESS ->
// RELEASE, with a dispatcher-priority round-robin pick and access timeout.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int CPU_NUM  = 4,
  parameter int PRIO_CPU = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CPU_NUM-1:0]            req_read,
  input  logic [CPU_NUM-1:0]            req_write,
  input  logic [CPU_NUM*ADDR_SIZE-1:0]  req_addr,
  input  logic [CPU_NUM*DATA_SIZE-1:0]  req_data,
  output logic [CPU_NUM-1:0]            grant,
  output logic [CPU_NUM-1:0]            rd_dn,
  output logic [CPU_NUM-1:0]            wr_dn,
  output logic [DATA_SIZE-1:0]          rdata,
  output logic [ADDR_SIZE-1:0]          mem_addr,
  output logic [DATA_SIZE-1:0]          mem_wdata,
  output logic                          mem_read_q,
  output logic                          mem_write_q,
  input  logic                          mem_read_dn,
  input  logic                          mem_write_dn,
  input  logic [DATA_SIZE-1:0]          mem_rdata,
  output logic                          bus_busy,
  output logic                          err
);

  localparam int                IDX_W    = $clog2(CPU_NUM);
  localparam logic [IDX_W-1:0]  PRIO_IDX = IDX_W'(PRIO_CPU);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(CPU_NUM - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  TO_ARM   = CNT_W'(TIMEOUT - 1);

  arb_state_e             state_q, state_d;
  logic [CPU_NUM-1:0]     grant_q, grant_d;
  logic [CPU_NUM-1:0]     rd_dn_q, rd_dn_d;
  logic [CPU_NUM-1:0]     wr_dn_q, wr_dn_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic                   op_write_q, op_write_d;
  logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_SIZE-1:0]   rdata_q, rdata_d;
  logic                   mem_read_d, mem_write_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [CPU_NUM-1:0]     req_any_s;
  logic                   pick_valid_s;
  logic [CPU_NUM-1:0]     pick_onehot_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   done_s;

  assign req_any_s = req_read | req_write;

  cpu_bus_arbiter_rr_pick #(
    .CPU_NUM (CPU_NUM),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req_any_s),
    .last_owner (last_owner_q),
    .prio_idx   (PRIO_IDX),
    .valid      (pick_valid_s),
    .onehot     (pick_onehot_s),
    .idx        (pick_idx_s)
  );

  // Next-state and next-output logic for the tenure FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    op_write_d   = op_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    rd_dn_d      = '0;
    wr_dn_d      = '0;
    err_d        = 1'b0;
    cnt_d        = cnt_q;
    // Only the dn matching the active strobe counts; a dropped strobe
    // (timeout) masks both.
    done_s       = (mem_read_q & mem_read_dn) | (mem_write_q & mem_write_dn);
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d     = ST_GRANT;
          grant_d     = pick_onehot_s;
          owner_d     = pick_idx_s;
          // Read wins when a core asks for both; its write gets a later tenure.
          op_write_d  = !req_read[pick_idx_s];
          mem_addr_d  = req_addr[int'(pick_idx_s)*ADDR_SIZE +: ADDR_SIZE];
          mem_wdata_d = req_data[int'(pick_idx_s)*DATA_SIZE +: DATA_SIZE];
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_d     = ST_ACCESS;
        mem_read_d  = !op_write_q;
        mem_write_d = op_write_q;
        cnt_d       = '0;
      end
      ST_ACCESS: begin
        if (done_s) begin
          state_d     = ST_RELEASE;
          grant_d     = '0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            rd_dn_d = grant_q;
            rdata_d = mem_rdata;
          end else begin
            wr_dn_d = grant_q;
          end
        end else if (cnt_q == TO_LAST) begin
          // err is high this cycle; close the tenure without any dn.
          state_d     = ST_RELEASE;
          grant_d     = '0;
        end else if (cnt_q == TO_ARM) begin
          // Counter hits TIMEOUT next cycle: raise err and drop the strobe then.
          err_d       = 1'b1;
          cnt_d       = TO_LAST;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d      = ST_IDLE;
        grant_d      = '0;
        last_owner_d = owner_q;
        cnt_d        = '0;
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any tenure without pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rd_dn_q      <= '0;
      wr_dn_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      op_write_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rd_dn_q      <= rd_dn_d;
      wr_dn_q      <= wr_dn_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      op_write_q   <= op_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign rd_dn     = rd_dn_q;
  assign wr_dn     = wr_dn_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign bus_busy  = (state_q != ST_IDLE);

endmodule
